// File: rtl/keccak_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// keccak_ctrl_pkg
// Shared definitions for the Keccak-f[200] round controller: the FSM state
// encoding and the round-count / round-index width constants.
// Optional build macro used by consumers of this package:
//   KECCAK_CTRL_RAND_STALL_EN - round progress gated by fresh-randomness valid.
// -----------------------------------------------------------------------------
package keccak_ctrl_pkg;

    // Keccak-f[200] runs 12 + 2*log2(8) = 18 rounds.
    localparam int KECCAK_NR_200 = 18;

    // Width of the round index fed to the round-constant lookup.
    localparam int ROUND_IDX_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/keccak_round_ctrl.sv
// -----------------------------------------------------------------------------
// keccak_round_ctrl
// Round-sequencing FSM for the Keccak-f[200] permutation core. Accepts a
// permutation request, pulses a load enable for the state register, then walks
// NR rounds of ROUND_CYCLES clocks each, driving the round index to the
// round-constant lookup and a state-update enable on the last cycle of every
// round. The result is offered with a valid/ready handshake.
//
// Ports:
//   ClkxCI       in   clock, rising edge
//   RstxRI       in   asynchronous active-high reset
//   StartxSI     in   permutation request, taken only while ReadyxSO=1
//   ReadyxSO     out  high while idle
//   LoadxSO      out  one-cycle load pulse for the state register
//   RoundEnxSO   out  state-register update enable, last cycle of each round
//   RoundNrxDO   out  current round index (0 outside ROUND)
//   OutValidxSO  out  permuted state available
//   OutReadyxSI  in   consumer takes the permuted state
//   RandValidxSI in   fresh randomness available (KECCAK_CTRL_RAND_STALL_EN only)
//   RandReqxSO   out  randomness requested, high in ROUND (KECCAK_CTRL_RAND_STALL_EN only)
//
// Build option: define KECCAK_CTRL_RAND_STALL_EN to let masked rounds stall
// until fresh randomness is available. Without it the block never stalls.
// -----------------------------------------------------------------------------
module keccak_round_ctrl
    import keccak_ctrl_pkg::*;
#(
    parameter int NR           = KECCAK_NR_200,
    parameter int ROUND_CYCLES = 2
) (
    input  logic                   ClkxCI,
    input  logic                   RstxRI,
    input  logic                   StartxSI,
    output logic                   ReadyxSO,
    output logic                   LoadxSO,
    output logic                   RoundEnxSO,
    output logic [ROUND_IDX_W-1:0] RoundNrxDO,
    output logic                   OutValidxSO,
`ifdef KECCAK_CTRL_RAND_STALL_EN
    input  logic                   RandValidxSI,
    output logic                   RandReqxSO,
`endif
    input  logic                   OutReadyxSI
);

    // A single-cycle round still needs a 1-bit counter so the datapath code
    // stays uniform; it simply never leaves 0.
    localparam int CYC_W = (ROUND_CYCLES > 1) ? $clog2(ROUND_CYCLES) : 1;

    localparam logic [CYC_W-1:0]       CYC_LAST   = CYC_W'(ROUND_CYCLES - 1);
    localparam logic [ROUND_IDX_W-1:0] ROUND_LAST = ROUND_IDX_W'(NR - 1);

    // Reject configurations the 5-bit round index cannot represent.
    if (NR < 1 || NR > 31 || ROUND_CYCLES < 1) begin : g_bad_params
        $error("keccak_round_ctrl: NR must be 1..31 and ROUND_CYCLES >= 1");
    end

    ctrl_state_t            state;
    ctrl_state_t            state_next;
    logic [ROUND_IDX_W-1:0] round;
    logic [ROUND_IDX_W-1:0] round_next;
    logic [CYC_W-1:0]       cyc;
    logic [CYC_W-1:0]       cyc_next;
    logic                   rand_ok;
    logic                   round_last_cycle;

`ifdef KECCAK_CTRL_RAND_STALL_EN
    // Round progress waits for fresh masking randomness.
    assign rand_ok    = RandValidxSI;
    assign RandReqxSO = (state == ROUND);
`else
    assign rand_ok = 1'b1;
`endif

    assign round_last_cycle = (state == ROUND) && (cyc == CYC_LAST) && rand_ok;

    // State and counter registers. Reset may hit at any time, including in
    // the middle of a permutation, and always returns to a clean idle.
    always_ff @(posedge ClkxCI or posedge RstxRI) begin
        if (RstxRI) begin
            state <= IDLE;
            round <= '0;
            cyc   <= '0;
        end else begin
            state <= state_next;
            round <= round_next;
            cyc   <= cyc_next;
        end
    end

    // Next-state and output decode. Outputs depend only on the registered
    // state and counters (plus the randomness gate when stalling is built in),
    // so no start or consumer-ready input reaches an output combinationally.
    // A start that arrives together with the consumer accept in DONE is
    // deliberately dropped: the controller goes back to IDLE first.
    always_comb begin
        state_next  = state;
        round_next  = round;
        cyc_next    = cyc;

        ReadyxSO    = (state == IDLE);
        LoadxSO     = (state == LOAD);
        OutValidxSO = (state == DONE);
        RoundEnxSO  = round_last_cycle;
        RoundNrxDO  = (state == ROUND) ? round : '0;

        unique case (state)
            IDLE: begin
                if (StartxSI) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                state_next = ROUND;
                round_next = '0;
                cyc_next   = '0;
            end
            ROUND: begin
                if (rand_ok) begin
                    if (cyc == CYC_LAST) begin
                        cyc_next = '0;
                        if (round == ROUND_LAST) begin
                            state_next = DONE;
                            round_next = '0;
                        end else begin
                            round_next = round + ROUND_IDX_W'(1);
                        end
                    end else begin
                        cyc_next = cyc + CYC_W'(1);
                    end
                end
            end
            DONE: begin
                if (OutReadyxSI) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: doc/keccak_round_ctrl.md
Name: keccak_round_ctrl

Overview:
- Round-sequencing FSM for the Keccak-f[200] permutation core (8-bit lanes, 18 rounds).
- Sits directly upstream of the round-constant lookup and drives its 5-bit round index.
- Issues load/round-update enables to the state register and supports multi-cycle (pipelined/masked) rounds.
- Uses a start/ready input handshake and a valid/ready output handshake with back-pressure.

Parameters:
- NR, 18, number of rounds per permutation (1..31).
- ROUND_CYCLES, 2, clock cycles per round, matching the round-datapath pipeline depth (>=1).

Ports:
- ClkxCI  in  1  clock, rising edge.
- RstxRI  in  1  reset, asynchronous, active-high.
- StartxSI  in  1  permutation request; accepted only when ReadyxSO=1.
- ReadyxSO  out  1  high iff FSM in IDLE.
- LoadxSO  out  1  one-cycle pulse: parent loads input state into state register.
- RoundEnxSO  out  1  state-register update enable; high on last cycle of each round.
- RoundNrxDO  out  5  current round index, fed to round-constant lookup.
- OutValidxSO  out  1  permuted state valid in state register.
- OutReadyxSI  in  1  consumer accepts output.

Behaviour:
- Reset (async, any time, including mid-permutation): state=IDLE, round=0, cycle counter=0.
  - Outputs during reset: ReadyxSO=1, LoadxSO=0, RoundEnxSO=0, RoundNrxDO=0, OutValidxSO=0.
- States and transitions:
  - IDLE -> LOAD on StartxSI=1.
  - LOAD (1 cycle, LoadxSO=1) -> ROUND with round=0, cyc=0.
  - ROUND: cyc increments each cycle. At cyc=ROUND_CYCLES-1, RoundEnxSO=1 and cyc wraps to 0.
    - If round=NR-1: -> DONE.
    - Else: round increments.
  - DONE: OutValidxSO=1, held until OutReadyxSI=1, then -> IDLE.
- All outputs decode from registered state/counters only: no combinational path from inputs to outputs.
- RoundNrxDO = round in ROUND; 0 in all other states. Changes only on round boundaries.
- Latency: start accepted in cycle t -> LoadxSO at t+1 -> rounds occupy t+2 .. t+1+NR*ROUND_CYCLES -> OutValidxSO first high at t+2+NR*ROUND_CYCLES (t+38 at defaults).
- Exactly NR RoundEnxSO pulses per permutation.
- StartxSI is ignored outside IDLE, with no queuing.
- Simultaneous OutReadyxSI=1 and StartxSI=1 in DONE: return to IDLE; the start is dropped (no bypass). The next start is accepted one cycle later at the earliest.
- ROUND_CYCLES=1: RoundEnxSO high every ROUND cycle. The cycle counter is 1 bit, held at 0.
- Cycle counter width: max(1, clog2(ROUND_CYCLES)). Round counter: 5 bits.
- Elaboration error if NR<1, NR>31 or ROUND_CYCLES<1.

Optional Feature:
- Macro: KECCAK_CTRL_RAND_STALL_EN.
- Defined:
  - Adds input RandValidxSI (1 bit) and output RandReqxSO (1 bit, high iff state=ROUND).
  - In ROUND, cyc/round advance and RoundEnxSO assert only when RandValidxSI=1.
  - Each stalled cycle adds one cycle of latency; RoundNrxDO is held during a stall.
  - Freshness for masked rounds is therefore guaranteed.
- Not defined: the ports are absent and RandValidxSI is treated as constant 1.

Decomposition:
- Shared package keccak_ctrl_pkg:
  - FSM state enum (IDLE, LOAD, ROUND, DONE).
  - Constants KECCAK_NR_200=18 and ROUND_IDX_W=5.
- No sub-module; the single FSM plus two counters stays flat. The round-constant lookup is instantiated by the parent, not inside this block.

Test Plan:
- Reset, StartxSI pulse at t, OutReadyxSI=1 -> LoadxSO at t+1; RoundNrxDO 0..17, each held 2 cycles; 18 RoundEnxSO pulses; OutValidxSO at t+38 for 1 cycle; ReadyxSO at t+39.
- OutReadyxSI low for 5 cycles in DONE -> OutValidxSO held, ReadyxSO=0, StartxSI pulses ignored; accept -> IDLE next cycle.
- StartxSI=1 while RoundNrxDO=7 -> no state change, total latency still 38.
- RstxRI asserted mid round 9 -> immediately IDLE, RoundNrxDO=0, no OutValidxSO. A new start then runs a full 18 rounds.
- ROUND_CYCLES=1 build -> RoundEnxSO high 18 consecutive cycles; OutValidxSO at t+20.
- KECCAK_CTRL_RAND_STALL_EN: RandValidxSI low 3 cycles during round 4 -> RoundNrxDO stays 4; OutValidxSO at t+41.
